control_unit: RTL and testbench

Sequencing controller for the six-instruction processor. Holds the program counter (PC) and instruction register (IR), fetches 16-bit instructions from the instruction ROM, and decodes them. Runs the multi-cycle FSM that drives the data-memory, register-file and ALU control lines; its ALU select output is the source of the ALU's 3-bit operation select.

---
 rtl/ctrl_pkg.sv | 45 ++++
 rtl/pc_reg.sv | 21 ++
 rtl/control_unit.sv | 114 +++++++++++
 tb/tb_control_unit.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the six-instruction processor: FSM states,
// opcodes and ALU operation selects used by control, ALU and datapath.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_B = 4'd5,
    S_STORE  = 4'd6,
    S_ADD    = 4'd7,
    S_SUB    = 4'd8,
    S_HALT   = 4'd9
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;

  localparam logic [2:0] ALU_ADD   = 3'd0;
  localparam logic [2:0] ALU_SUB   = 3'd1;
  localparam logic [2:0] ALU_PASSA = 3'd2;
  localparam logic [2:0] ALU_XOR   = 3'd3;
  localparam logic [2:0] ALU_OR    = 3'd4;
  localparam logic [2:0] ALU_AND   = 3'd5;
  localparam logic [2:0] ALU_INC   = 3'd6;

  // Maps an opcode to the first execute state; anything unknown runs as NOOP.
  function automatic state_t decode_op(input logic [3:0] op);
    case (op)
      OP_STORE: return S_STORE;
      OP_LOAD:  return S_LOAD_A;
      OP_ADD:   return S_ADD;
      OP_SUB:   return S_SUB;
      OP_HALT:  return S_HALT;
      default:  return S_NOOP;
    endcase
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: synchronous clear, increment enable,
// wraps modulo 2^PC_W.
module pc_reg #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            clr,
  input  logic            inc,
  output logic [PC_W-1:0] pc
);

  // Clear wins over increment so reset always returns the PC to zero.
  always_ff @(posedge clk) begin
    if (clr) begin
      pc <= '0;
    end else if (inc) begin
      pc <= pc + PC_W'(1);
    end
  end

endmodule

// File: rtl/control_unit.sv
// Sequencing controller: holds PC and IR, fetches and decodes 16-bit
// instructions and drives memory, register-file and ALU control lines.
module control_unit
  import ctrl_pkg::*;
#(
  parameter int PC_W = 7
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic [15:0]     Instr,
  output logic [PC_W-1:0] PC_Addr,
  output logic [7:0]      D_Addr,
  output logic            D_Wr,
  output logic            RF_s,
  output logic [3:0]      RF_W_Addr,
  output logic            RF_W_en,
  output logic [3:0]      RF_Ra_Addr,
  output logic [3:0]      RF_Rb_Addr,
  output logic [2:0]      ALU_s0,
  output logic [3:0]      State,
  output logic            Halted
);

  state_t          state;
  state_t          next_state;
  logic [15:0]     ir;
  logic [PC_W-1:0] pc;
  logic            d_wr_raw;
  logic            rf_w_en_raw;

  pc_reg #(.PC_W(PC_W)) u_pc (
    .clk (Clk),
    .clr (Reset),
    .inc (state == S_FETCH),
    .pc  (pc)
  );

  // State register and instruction latch; IR captures ROM data in FETCH.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_INIT;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == S_FETCH) begin
        ir <= Instr;
      end
    end
  end

  // Next-state logic: fetch/decode loop, LOAD takes two execute cycles, HALT sticks.
  always_comb begin
    next_state = state;
    case (state)
      S_INIT:   next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: next_state = decode_op(ir[15:12]);
      S_LOAD_A: next_state = S_LOAD_B;
      S_HALT:   next_state = S_HALT;
      S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: next_state = S_FETCH;
      default:  next_state = S_INIT;
    endcase
  end

  // Moore output decode from the state register and IR fields.
  always_comb begin
    D_Addr      = '0;
    d_wr_raw    = 1'b0;
    RF_s        = 1'b0;
    RF_W_Addr   = '0;
    rf_w_en_raw = 1'b0;
    RF_Ra_Addr  = '0;
    RF_Rb_Addr  = '0;
    ALU_s0      = ALU_ADD;
    Halted      = 1'b0;
    case (state)
      S_LOAD_A: begin
        D_Addr = ir[11:4];
        RF_s   = 1'b1;
      end
      S_LOAD_B: begin
        D_Addr      = ir[11:4];
        RF_s        = 1'b1;
        RF_W_Addr   = ir[3:0];
        rf_w_en_raw = 1'b1;
      end
      S_STORE: begin
        D_Addr     = ir[11:4];
        RF_Ra_Addr = ir[3:0];
        ALU_s0     = ALU_PASSA;
        d_wr_raw   = 1'b1;
      end
      S_ADD, S_SUB: begin
        RF_Ra_Addr  = ir[11:8];
        RF_Rb_Addr  = ir[7:4];
        RF_W_Addr   = ir[3:0];
        rf_w_en_raw = 1'b1;
        ALU_s0      = (state == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      S_HALT: begin
        Halted = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Write strobes are masked by Reset so an in-flight write never commits.
  assign D_Wr    = d_wr_raw & ~Reset;
  assign RF_W_en = rf_w_en_raw & ~Reset;
  assign PC_Addr = pc;
  assign State   = state;

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit: an instruction-level model predicts
// every output each cycle for directed and randomized programs.
module tb_control_unit;

  localparam int PC_W     = 7;
  localparam int ROM_SZ   = 1 << PC_W;
  localparam int PH_INIT  = 0;
  localparam int PH_FETCH = 1;
  localparam int PH_DEC   = 2;
  localparam int PH_EXEC  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [15:0]     instr;
  logic [PC_W-1:0] pcAddr;
  logic [7:0]      dAddr;
  logic            dWr;
  logic            rfS;
  logic [3:0]      rfWAddr;
  logic            rfWEn;
  logic [3:0]      rfRaAddr;
  logic [3:0]      rfRbAddr;
  logic [2:0]      aluS0;
  logic [3:0]      stateOut;
  logic            halted;

  logic [15:0]     rom [ROM_SZ];
  logic [37:0]     obsVec;
  logic [37:0]     expVec;

  int              testsRun = 0;
  int              failCount = 0;

  int              mPhase;
  int              mExec;
  logic [PC_W-1:0] mPc;
  logic [15:0]     mIr;

  control_unit #(.PC_W(PC_W)) dut (
    .Clk        (clk),
    .Reset      (rst),
    .Instr      (instr),
    .PC_Addr    (pcAddr),
    .D_Addr     (dAddr),
    .D_Wr       (dWr),
    .RF_s       (rfS),
    .RF_W_Addr  (rfWAddr),
    .RF_W_en    (rfWEn),
    .RF_Ra_Addr (rfRaAddr),
    .RF_Rb_Addr (rfRbAddr),
    .ALU_s0     (aluS0),
    .State      (stateOut),
    .Halted     (halted)
  );

  always #5 clk = ~clk;

  assign instr  = rom[pcAddr];
  assign obsVec = {stateOut, pcAddr, dAddr, dWr, rfS, rfWAddr, rfWEn,
                   rfRaAddr, rfRbAddr, aluS0, halted};

  // Expected outputs for the current model position, built from instruction semantics.
  function automatic logic [37:0] modelOutputs();
    logic [3:0] st, ra, rb, wa, op;
    logic [7:0] da;
    logic       dw, rs, we, hl;
    logic [2:0] alu;
    st = 0; ra = 0; rb = 0; wa = 0; da = 0; dw = 0; rs = 0; we = 0; hl = 0; alu = 0;
    op = mIr[15:12];
    case (mPhase)
      PH_INIT:  st = 4'd0;
      PH_FETCH: st = 4'd1;
      PH_DEC:   st = 4'd2;
      default: begin
        case (op)
          4'd1: begin st = 4'd6; da = mIr[11:4]; ra = mIr[3:0]; alu = 3'd2; dw = 1; end
          4'd2: begin
            st = (mExec == 0) ? 4'd4 : 4'd5;
            da = mIr[11:4];
            rs = 1;
            if (mExec != 0) begin wa = mIr[3:0]; we = 1; end
          end
          4'd3, 4'd4: begin
            st  = (op == 4'd3) ? 4'd7 : 4'd8;
            ra  = mIr[11:8]; rb = mIr[7:4]; wa = mIr[3:0]; we = 1;
            alu = (op == 4'd3) ? 3'd0 : 3'd1;
          end
          4'd5: begin st = 4'd9; hl = 1; end
          default: st = 4'd3;
        endcase
      end
    endcase
    if (rst) begin dw = 0; we = 0; end
    return {st, mPc, da, dw, rs, wa, we, ra, rb, alu, hl};
  endfunction

  // Advances the model across one rising edge using the current reset level.
  task automatic modelAdvance();
    if (rst) begin
      mPhase = PH_INIT; mPc = '0; mIr = '0; mExec = 0;
    end else begin
      case (mPhase)
        PH_INIT:  mPhase = PH_FETCH;
        PH_FETCH: begin mIr = rom[mPc]; mPc = mPc + 1'b1; mPhase = PH_DEC; end
        PH_DEC:   begin mPhase = PH_EXEC; mExec = 0; end
        default: begin
          if (mIr[15:12] == 4'd5) mPhase = PH_EXEC;
          else if (mIr[15:12] == 4'd2 && mExec == 0) mExec = 1;
          else mPhase = PH_FETCH;
        end
      endcase
    end
  endtask

  task automatic applyStimulus(input logic r);
    @(negedge clk);
    rst = r;
    #1;
  endtask

  task automatic doReset();
    applyStimulus(1'b1); modelAdvance();
    applyStimulus(1'b1); modelAdvance();
  endtask

  task automatic clearRom();
    for (int i = 0; i < ROM_SZ; i++) rom[i] = 16'h0000;
  endtask

  task automatic test_reset();
    clearRom();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    modelAdvance();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1);
      expVec = modelOutputs();
      testsRun++;
      if (obsVec !== expVec) begin
        failCount++;
        $display("[TB] FAIL reset cycle %0d: got %h want %h", i, obsVec, expVec);
      end
      modelAdvance();
    end
  endtask

  task automatic test_load();
    logic [3:0] seen [6];
    logic [3:0] want [6];
    int wenCount;
    want = '{4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd1};
    wenCount = 0;
    clearRom();
    rom[0] = 16'h2053;
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0);
      expVec = modelOutputs();
      seen[i] = stateOut;
      if (rfWEn) wenCount++;
      testsRun++;
      if (obsVec !== expVec) begin
        failCount++;
        $display("[TB] FAIL load cycle %0d: got %h want %h", i, obsVec, expVec);
      end
      modelAdvance();
    end
    for (int i = 0; i < 6; i++) begin
      testsRun++;
      if (seen[i] !== want[i]) begin
        failCount++;
        $display("[TB] FAIL load_state_seq step %0d: got %0d want %0d", i, seen[i], want[i]);
      end
    end
    testsRun++;
    if (wenCount !== 1) begin
      failCount++;
      $display("[TB] FAIL load_wen_pulses: got %0d want 1", wenCount);
    end
  endtask

  task automatic test_store();
    int wrCount;
    wrCount = 0;
    clearRom();
    rom[0] = 16'h1A07;
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0);
      expVec = modelOutputs();
      if (dWr) wrCount++;
      testsRun++;
      if (obsVec !== expVec) begin
        failCount++;
        $display("[TB] FAIL store cycle %0d: got %h want %h", i, obsVec, expVec);
      end
      modelAdvance();
    end
    testsRun++;
    if (stateOut !== 4'd1 || wrCount !== 1) begin
      failCount++;
      $display("[TB] FAIL store_length: state %0d writes %0d want state 1 writes 1", stateOut, wrCount);
    end
  endtask

  task automatic test_add_sub();
    int wenCount;
    wenCount = 0;
    clearRom();
    rom[0] = 16'h3124;
    rom[1] = 16'h4124;
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0);
      expVec = modelOutputs();
      if (rfWEn) wenCount++;
      testsRun++;
      if (obsVec !== expVec) begin
        failCount++;
        $display("[TB] FAIL add_sub cycle %0d: got %h want %h", i, obsVec, expVec);
      end
      modelAdvance();
    end
    testsRun++;
    if (wenCount !== 2) begin
      failCount++;
      $display("[TB] FAIL add_sub_wen_pulses: got %0d want 2", wenCount);
    end
  endtask

  task automatic test_illegal_halt();
    clearRom();
    rom[0] = 16'hF000;
    rom[1] = 16'h5000;
    doReset();
    for (int i = 0; i < 26; i++) begin
      applyStimulus(1'b0);
      expVec = modelOutputs();
      testsRun++;
      if (obsVec !== expVec) begin
        failCount++;
        $display("[TB] FAIL illegal_halt cycle %0d: got %h want %h", i, obsVec, expVec);
      end
      modelAdvance();
    end
    testsRun++;
    if (halted !== 1'b1 || pcAddr !== 7'd2) begin
      failCount++;
      $display("[TB] FAIL halt_hold: halted %b pc %0d want halted 1 pc 2", halted, pcAddr);
    end
  endtask

  task automatic test_reset_during_store();
    clearRom();
    rom[0] = 16'h1A07;
    doReset();
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i == 3);
      expVec = modelOutputs();
      testsRun++;
      if (obsVec !== expVec) begin
        failCount++;
        $display("[TB] FAIL reset_in_store cycle %0d: got %h want %h", i, obsVec, expVec);
      end
      if (i == 3) begin
        testsRun++;
        if (dWr !== 1'b0) begin
          failCount++;
          $display("[TB] FAIL reset_masks_dwr: got %b want 0", dWr);
        end
      end
      modelAdvance();
    end
  endtask

  task automatic test_pc_wrap();
    logic sawWrap;
    sawWrap = 1'b0;
    clearRom();
    doReset();
    for (int i = 0; i < 1 + ROM_SZ * 3 + 3; i++) begin
      applyStimulus(1'b0);
      expVec = modelOutputs();
      if (i > 3 && pcAddr === '0) sawWrap = 1'b1;
      testsRun++;
      if (obsVec !== expVec) begin
        failCount++;
        $display("[TB] FAIL pc_wrap cycle %0d: got %h want %h", i, obsVec, expVec);
      end
      modelAdvance();
    end
    testsRun++;
    if (sawWrap !== 1'b1) begin
      failCount++;
      $display("[TB] FAIL pc_wrap_seen: got %b want 1", sawWrap);
    end
  endtask

  task automatic test_random();
    logic [15:0] w;
    for (int round = 0; round < 3; round++) begin
      for (int a = 0; a < ROM_SZ; a++) begin
        w = 16'($urandom);
        if (w[15:12] == 4'd5 && $urandom_range(0, 7) != 0) w[15:12] = 4'd0;
        rom[a] = w;
      end
      doReset();
      for (int i = 0; i < 300; i++) begin
        applyStimulus($urandom_range(0, 63) == 0);
        expVec = modelOutputs();
        testsRun++;
        if (obsVec !== expVec) begin
          failCount++;
          $display("[TB] FAIL random r%0d cycle %0d: got %h want %h", round, i, obsVec, expVec);
        end
        modelAdvance();
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_add_sub();
    test_illegal_halt();
    test_reset_during_store();
    test_pc_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
